// File: rtl/conv_frame_ctrl.sv
// ---------------------------------------------------------------------------
// conv_frame_ctrl
//
// Frame sequencer for the 3x3 line buffer. A start request clears the line
// buffer, then streams one IMG_WIDTH x IMG_HEIGHT frame from the image RAM
// into it in raster order. Reads pause while the downstream MAC stage holds
// acc_ready low. Windows reported back by the line buffer are counted, and
// the frame ends with a one-cycle done pulse. err is raised on a drain
// timeout or on a surplus window.
//
// Ports:
//   clk              system clock, rising edge
//   rst              asynchronous active-high reset
//   start            one-cycle frame request, honoured only when idle
//   acc_ready        downstream can accept windows; low pauses RAM reads
//   mem_rd_en        image RAM read strobe
//   mem_addr         image RAM read address
//   mem_rdata        RAM read data, valid one cycle after mem_rd_en
//   lb_rst           line buffer clear pulse
//   pixel_valid      pixel strobe to the line buffer
//   pixel_in         pixel data to the line buffer
//   lb_window_valid  window_valid returned by the line buffer
//   win_count        windows received in the current frame
//   busy             high from CLEAR through DONE
//   done             one-cycle pulse at frame completion
//   err              sticky error, cleared by the next accepted start
//
// Optional build macro CONV_CTRL_PERF_EN adds two performance counters:
//   stall_cycles     FEED cycles spent with acc_ready low
//   frame_cycles     cycles from CLEAR through DONE inclusive
// ---------------------------------------------------------------------------
module conv_frame_ctrl #(
    parameter int IMG_WIDTH  = 8,
    parameter int IMG_HEIGHT = 8,
    parameter int ADDR_W     = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              acc_ready,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              lb_rst,
    output logic              pixel_valid,
    output logic [7:0]        pixel_in,
    input  logic              lb_window_valid,
    output logic [15:0]       win_count,
    output logic              busy,
    output logic              done,
    output logic              err
`ifdef CONV_CTRL_PERF_EN
    ,
    output logic [15:0]       stall_cycles,
    output logic [15:0]       frame_cycles
`endif
);

    localparam int NPIX = IMG_WIDTH * IMG_HEIGHT;
    localparam int NWIN = (IMG_WIDTH - 2) * (IMG_HEIGHT - 2);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
    localparam logic [15:0]       NWIN_C    = 16'(NWIN);
    localparam logic [1:0]        DRAIN_MAX = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] rd_ptr;
    logic [1:0]        drain_cnt;
    logic              rd_en_p1;
    logic              start_acc;
    logic              drain_timeout;
    logic              win_reached;

    // ---------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------------------------------------------------------
    // Next-state and control decode
    // ---------------------------------------------------------------
    always_comb begin
        state_nxt     = state;
        lb_rst        = 1'b0;
        mem_rd_en     = 1'b0;
        done          = 1'b0;
        busy          = 1'b1;
        start_acc     = 1'b0;
        drain_timeout = 1'b0;
        // Look at the window arriving this cycle as well, so the final
        // window moves the FSM to DONE without an extra cycle of latency.
        win_reached   = (win_count == NWIN_C) ||
                        (lb_window_valid && (win_count == NWIN_C - 16'd1));

        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    start_acc = 1'b1;
                    state_nxt = S_CLEAR;
                end
            end
            S_CLEAR: begin
                lb_rst    = 1'b1;
                state_nxt = S_FEED;
            end
            S_FEED: begin
                if (acc_ready) begin
                    mem_rd_en = 1'b1;
                    if (rd_ptr == LAST_ADDR) begin
                        state_nxt = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (win_reached) begin
                    state_nxt = S_DONE;
                end else if (drain_cnt == DRAIN_MAX) begin
                    drain_timeout = 1'b1;
                    state_nxt     = S_DONE;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                busy      = 1'b0;
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign mem_addr = mem_rd_en ? rd_ptr : '0;

    // ---------------------------------------------------------------
    // Read pointer, drain timer and window bookkeeping
    // ---------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr    <= '0;
            drain_cnt <= 2'd0;
            win_count <= 16'd0;
            err       <= 1'b0;
        end else begin
            if (start_acc) begin
                rd_ptr <= '0;
            end else if (mem_rd_en) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end

            // Timer is zero on DRAIN entry and counts DRAIN cycles.
            if (state == S_DRAIN) begin
                drain_cnt <= drain_cnt + 2'd1;
            end else begin
                drain_cnt <= 2'd0;
            end

            if (start_acc) begin
                win_count <= 16'd0;
                err       <= 1'b0;
            end else begin
                if (busy && lb_window_valid) begin
                    // A window beyond the expected total is an error; the
                    // count stays pinned at NWIN.
                    if (win_count == NWIN_C) begin
                        err <= 1'b1;
                    end else begin
                        win_count <= win_count + 16'd1;
                    end
                end
                if (drain_timeout) begin
                    err <= 1'b1;
                end
            end
        end
    end

    // ---------------------------------------------------------------
    // Stage p1: pixel forwarding, one cycle behind the read strobe.
    // Runs regardless of FSM state so an in-flight read always lands.
    // ---------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_en_p1 <= 1'b0;
        end else begin
            rd_en_p1 <= mem_rd_en;
        end
    end

    assign pixel_valid = rd_en_p1;
    // RAM data is valid in the cycle after the strobe, which is the cycle
    // pixel_valid is high; outside that cycle the bus is held at zero.
    assign pixel_in    = rd_en_p1 ? mem_rdata : 8'd0;

`ifdef CONV_CTRL_PERF_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= 16'd0;
            frame_cycles <= 16'd0;
        end else if (start_acc) begin
            stall_cycles <= 16'd0;
            frame_cycles <= 16'd0;
        end else begin
            if (state == S_FEED && !acc_ready) begin
                stall_cycles <= sat_inc(stall_cycles);
            end
            if (busy) begin
                frame_cycles <= sat_inc(frame_cycles);
            end
        end
    end
`endif

endmodule
